// File: rtl/rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : rx_fifo
//  Brief    : Receive-side FIFO. The serial receiver pushes words over a
//             4-phase REQ/ACK handshake that crosses through a 2-flop
//             synchroniser. The APB side pops words with single-cycle strobes.
//             Also raises the watermark and sticky overrun interrupts.
//  Revision : 1.0 - initial release
// ============================================================================
module rx_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 2,
  parameter int RX_WATERMARK = 2
) (
  input  logic                  i_PCLK,
  input  logic                  i_CLEAR,
  input  logic [DATA_WIDTH-1:0] i_RXDATA,
  input  logic                  i_RX_VALID,
  output logic                  o_RX_ACK,
  input  logic                  i_PSEL,
  input  logic                  i_PWRITE,
  output logic [DATA_WIDTH-1:0] o_PRDATA,
  output logic [ADDR_WIDTH:0]   o_RX_LEVEL,
  output logic                  o_RX_NE,
  output logic                  o_RX_FULL,
  output logic                  o_SSPRXINTR,
  output logic                  o_SSPRORINTR,
  input  logic                  i_ROR_CLR
);

  localparam int                DEPTH  = 1 << ADDR_WIDTH;
  localparam int                LVL_W  = ADDR_WIDTH + 1;
  localparam logic [LVL_W-1:0]  C_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]  C_WM   = LVL_W'(RX_WATERMARK);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  s1_q, s2_q;
  logic                  ack_q, ack_d;
  logic                  ror_q, ror_d;

  logic w_wr_stb, w_empty, w_full, w_pop, w_wr_ok, w_overrun;

  // Handshake edge detect and push/pop qualification
  always_comb begin
    w_wr_stb  = s1_q & ~s2_q;
    w_empty   = (level_q == '0);
    w_full    = (level_q == C_FULL);
    w_pop     = i_PSEL & ~i_PWRITE & ~w_empty;
    // A pop in the same cycle frees the slot the write needs
    w_wr_ok   = w_wr_stb & (~w_full | w_pop);
    w_overrun = w_wr_stb & w_full & ~w_pop;
  end

  // Next-state for pointers, level, ACK and the sticky overrun flag
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    ack_d    = ack_q;
    ror_d    = ror_q;
    if (w_pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    if (w_wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    case ({w_wr_ok, w_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    // ACK is given even for a dropped word so the receiver never stalls
    if (w_wr_stb)   ack_d = 1'b1;
    else if (!s1_q) ack_d = 1'b0;
    // Setting wins over a coincident clear
    if (w_overrun)      ror_d = 1'b1;
    else if (i_ROR_CLR) ror_d = 1'b0;
  end

  // Control state registers with asynchronous clear
  always_ff @(posedge i_PCLK or posedge i_CLEAR) begin
    if (i_CLEAR) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      ack_q    <= 1'b0;
      ror_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      s1_q     <= i_RX_VALID;
      s2_q     <= s1_q;
      ack_q    <= ack_d;
      ror_q    <= ror_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge i_PCLK) begin
    if (w_wr_ok) mem_q[wr_ptr_q] <= i_RXDATA;
  end

  // Status decode from the registered level; head word forced to 0 when empty
  always_comb begin
    o_RX_ACK     = ack_q;
    o_SSPRORINTR = ror_q;
    o_RX_LEVEL   = level_q;
    o_RX_NE      = ~w_empty;
    o_RX_FULL    = w_full;
    o_SSPRXINTR  = (level_q >= C_WM);
    o_PRDATA     = w_empty ? '0 : mem_q[rd_ptr_q];
  end

endmodule
`default_nettype wire

// File: tb/tb_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rx_fifo
//  Brief    : Directed self-checking bench for rx_fifo.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rx_fifo;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       psel = 1'b0;
  logic       pwrite = 1'b0;
  logic       ror_clr = 1'b0;
  logic       ack, ne, full, rxintr, rorintr;
  logic [7:0] prdata;
  logic [2:0] level;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rx_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .RX_WATERMARK(2)) dut (
    .i_PCLK      (clk),
    .i_CLEAR     (clear),
    .i_RXDATA    (rx_data),
    .i_RX_VALID  (rx_valid),
    .o_RX_ACK    (ack),
    .i_PSEL      (psel),
    .i_PWRITE    (pwrite),
    .o_PRDATA    (prdata),
    .o_RX_LEVEL  (level),
    .o_RX_NE     (ne),
    .o_RX_FULL   (full),
    .o_SSPRXINTR (rxintr),
    .o_SSPRORINTR(rorintr),
    .i_ROR_CLR   (ror_clr)
  );

  // Stimulus: one clean reset pulse
  task automatic do_reset();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Stimulus: full 4-phase push; a missing ACK edge is a failure
  task automatic push(input logic [7:0] d);
    bit seen;
    @(negedge clk);
    rx_data  = d;
    rx_valid = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (ack) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL push_ack(%h): ack=%b required 1 within 8 cycles", d, ack);
    end
    rx_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (!ack) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL push_ack_low(%h): ack=%b required 0 within 8 cycles", d, ack);
    end
  endtask

  // Stimulus: one single-cycle read strobe
  task automatic pop();
    @(negedge clk);
    psel = 1'b1;
    pwrite = 1'b0;
    @(negedge clk);
    psel = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rx_data = 8'h77;
    rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (ack !== 1'b1 || level !== 3'd1) begin
      fails++;
      $display("FAIL reset_pre: ack=%b level=%0d required ack=1 level=1", ack, level);
    end
    #2 clear = 1'b1;
    #1;
    tests++;
    if ({ack, ne, full, rxintr, rorintr, prdata, level} !== 16'h0) begin
      fails++;
      $display("FAIL reset_async: ack=%b ne=%b full=%b rx=%b ror=%b prdata=%h level=%0d required all 0",
               ack, ne, full, rxintr, rorintr, prdata, level);
    end
    rx_valid = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_push();
    do_reset();
    @(negedge clk);
    rx_data = 8'hA1;
    rx_valid = 1'b1;
    @(negedge clk);   // after E0
    tests++;
    if (ack !== 1'b0 || level !== 3'd0) begin
      fails++;
      $display("FAIL push1_e0: ack=%b level=%0d required ack=0 level=0", ack, level);
    end
    @(negedge clk);   // after E1
    tests++;
    if (ack !== 1'b1 || prdata !== 8'hA1 || level !== 3'd1 || ne !== 1'b1) begin
      fails++;
      $display("FAIL push1_e1: ack=%b prdata=%h level=%0d ne=%b required 1 a1 1 1", ack, prdata, level, ne);
    end
    rx_valid = 1'b0;
    @(negedge clk);   // after F0
    tests++;
    if (ack !== 1'b1) begin
      fails++;
      $display("FAIL push1_f0: ack=%b required 1", ack);
    end
    @(negedge clk);   // after F1
    tests++;
    if (ack !== 1'b0 || level !== 3'd1) begin
      fails++;
      $display("FAIL push1_f1: ack=%b level=%0d required ack=0 level=1", ack, level);
    end
  endtask

  task automatic test_full_overrun();
    logic [7:0] words [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(words[i]);
      tests++;
      if (level !== 3'(i + 1) || rxintr !== (i >= 1) || full !== (i == 3)) begin
        fails++;
        $display("FAIL fill[%0d]: level=%0d rxintr=%b full=%b required %0d %b %b",
                 i, level, rxintr, full, i + 1, (i >= 1), (i == 3));
      end
    end
    push(8'hE5);
    tests++;
    if (rorintr !== 1'b1 || prdata !== 8'hA1 || level !== 3'd4) begin
      fails++;
      $display("FAIL overrun: ror=%b prdata=%h level=%0d required 1 a1 4", rorintr, prdata, level);
    end
    @(negedge clk);
    ror_clr = 1'b1;
    @(negedge clk);
    ror_clr = 1'b0;
    tests++;
    if (rorintr !== 1'b0) begin
      fails++;
      $display("FAIL ror_clr: ror=%b required 0", rorintr);
    end
  endtask

  task automatic test_drain();
    logic [7:0] words [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (prdata !== words[i]) begin
        fails++;
        $display("FAIL drain[%0d]: prdata=%h required %h", i, prdata, words[i]);
      end
      pop();
    end
    tests++;
    if (ne !== 1'b0 || level !== 3'd0 || prdata !== 8'h00) begin
      fails++;
      $display("FAIL drain_empty: ne=%b level=%0d prdata=%h required 0 0 00", ne, level, prdata);
    end
    pop();
    tests++;
    if (level !== 3'd0 || prdata !== 8'h00 || rxintr !== 1'b0) begin
      fails++;
      $display("FAIL pop_empty: level=%0d prdata=%h rxintr=%b required 0 00 0", level, prdata, rxintr);
    end
  endtask

  task automatic test_full_simul();
    logic [7:0] exp [4] = '{8'hB2, 8'hC3, 8'hD4, 8'h5A};
    do_reset();
    push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
    @(negedge clk);
    rx_data = 8'h5A;
    rx_valid = 1'b1;
    @(negedge clk);   // s1=1 now; strobe is live for the next edge
    psel = 1'b1;
    pwrite = 1'b0;
    @(negedge clk);
    psel = 1'b0;
    tests++;
    if (level !== 3'd4 || rorintr !== 1'b0 || ack !== 1'b1 || prdata !== 8'hB2) begin
      fails++;
      $display("FAIL simul: level=%0d ror=%b ack=%b prdata=%h required 4 0 1 b2", level, rorintr, ack, prdata);
    end
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (prdata !== exp[i]) begin
        fails++;
        $display("FAIL simul_drain[%0d]: prdata=%h required %h", i, prdata, exp[i]);
      end
      pop();
    end
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      d = 8'h10 + 8'(i);
      push(d);
      tests++;
      if (prdata !== d || level !== 3'd1) begin
        fails++;
        $display("FAIL wrap[%0d]: prdata=%h level=%0d required %h 1", i, prdata, level, d);
      end
      pop();
    end
    tests++;
    if (level !== 3'd0 || ne !== 1'b0) begin
      fails++;
      $display("FAIL wrap_end: level=%0d ne=%b required 0 0", level, ne);
    end
  endtask

  initial begin
    clear = 1'b1;
    repeat (2) @(negedge clk);
    clear = 1'b0;
    test_reset();
    test_single_push();
    test_full_overrun();
    test_drain();
    test_full_simul();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
